// File: rtl/act_pkg.sv
// Shared definitions for the activation array: mode encodings, divide-by-6
// reciprocal and fixed-point constant helper.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_HSWISH   = 2'b00,
    ACT_HSIGMOID = 2'b01,
    ACT_RELU6    = 2'b10,
    ACT_BYPASS   = 2'b11
  } act_mode_e;

  localparam int ACT_RECIP6      = 10923;
  localparam int ACT_RECIP_SHIFT = 16;
  localparam int ACT_THREE_INT   = 3;
  localparam int ACT_SIX_INT     = 6;

  function automatic int act_fixed(input int whole, input int frac_bits);
    return whole << frac_bits;
  endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation pipeline (S1 clamp, S2 multiply/select, S3 divide/saturate).
// The saturation flag output exists only when ACT_SAT_CNT_EN is defined.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 26,
  parameter int FRAC_BITS  = 7,
  parameter int OUT_SIZE   = 14,
  parameter int RECIP6     = ACT_RECIP6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic                         ld1,
  input  logic                         ld2,
  input  logic                         ld3,
  input  act_mode_e                    mode_s1,
  input  act_mode_e                    mode_s2,
  output logic signed [OUT_SIZE-1:0]   q
`ifdef ACT_SAT_CNT_EN
  ,
  output logic                         sat
`endif
);

  localparam int RW = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + FRAC_BITS + 4;
  localparam int MW = DATA_WIDTH + RW;
  localparam int QW = PW + ACT_RECIP_SHIFT + 1;

  localparam logic signed [RW-1:0] THREE = RW'(act_fixed(ACT_THREE_INT, FRAC_BITS));
  localparam logic signed [RW-1:0] SIX   = RW'(act_fixed(ACT_SIX_INT, FRAC_BITS));
  localparam logic signed [PW-1:0] SIX_P = PW'(act_fixed(ACT_SIX_INT, FRAC_BITS));
  localparam logic signed [QW-1:0] K     = QW'(RECIP6);
  localparam logic signed [QW-1:0] QMAX  = QW'((1 << (OUT_SIZE - 1)) - 1);
  localparam logic signed [QW-1:0] QMIN  = QW'(-(1 << (OUT_SIZE - 1)));

  logic signed [DATA_WIDTH-1:0] x_reg;
  logic signed [RW-1:0]         x_ext, sum, r_next, r_reg;
  logic signed [MW-1:0]         xm, rm, prod2;
  logic signed [PW-1:0]         xp, p_next, p_reg;
  logic signed [QW-1:0]         pq, prod3, qfull;
  logic signed [OUT_SIZE-1:0]   q_next, q_reg;

  // S1: r = clamp(x + 3, 0, 6); one extra bit keeps the sum from wrapping
  always_comb begin
    x_ext = x;
    sum   = x_ext + THREE;
    if (sum < 0)
      r_next = '0;
    else if (sum > SIX)
      r_next = SIX;
    else
      r_next = sum;
  end

  // S2: per-mode numerator, kept at full width until the final saturation
  always_comb begin
    xm    = x_reg;
    rm    = r_reg;
    prod2 = xm * rm;
    xp    = x_reg;
    case (mode_s1)
      ACT_HSWISH:   p_next = PW'(prod2 >>> FRAC_BITS);
      ACT_HSIGMOID: p_next = r_reg;
      ACT_RELU6: begin
        if (xp < 0)
          p_next = '0;
        else if (xp > SIX_P)
          p_next = SIX_P;
        else
          p_next = xp;
      end
      default:      p_next = xp;
    endcase
  end

  // S3: divide by 6 via reciprocal multiply (arithmetic shift floors), then saturate
  always_comb begin
    pq    = p_reg;
    prod3 = pq * K;
    case (mode_s2)
      ACT_HSWISH, ACT_HSIGMOID: qfull = prod3 >>> ACT_RECIP_SHIFT;
      default:                  qfull = pq;
    endcase
    if (qfull > QMAX)
      q_next = QMAX[OUT_SIZE-1:0];
    else if (qfull < QMIN)
      q_next = QMIN[OUT_SIZE-1:0];
    else
      q_next = qfull[OUT_SIZE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      r_reg <= '0;
      p_reg <= '0;
      q_reg <= '0;
    end else begin
      if (ld1) begin
        x_reg <= x;
        r_reg <= r_next;
      end
      if (ld2) p_reg <= p_next;
      if (ld3) q_reg <= q_next;
    end
  end

  assign q = q_reg;

`ifdef ACT_SAT_CNT_EN
  logic sat_next, sat_reg;

  assign sat_next = (qfull > QMAX) || (qfull < QMIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_reg <= 1'b0;
    else if (ld3)
      sat_reg <= sat_next;
  end

  assign sat = sat_reg;
`endif

endmodule

// File: rtl/act_array.sv
// LANES-wide pipelined activation array with valid/ready flow control and bubble collapsing.
// Optional saturation counter (sat_clr / sat_count) is built when ACT_SAT_CNT_EN is defined.
module act_array
  import act_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 26,
  parameter int FRAC_BITS  = 7,
  parameter int OUT_SIZE   = 14,
  parameter int RECIP6     = ACT_RECIP6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic [1:0]                  in_mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_SIZE*LANES-1:0]   out_data,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef ACT_SAT_CNT_EN
  ,
  input  logic                        sat_clr,
  output logic [31:0]                 sat_count
`endif
);

  logic      v1_reg, v2_reg, v3_reg;
  logic      adv1, adv2, adv3;
  logic      ld1, ld2, ld3;
  act_mode_e mode_s1_reg, mode_s2_reg;

`ifdef ACT_SAT_CNT_EN
  logic [LANES-1:0] sat_vec;
`endif

  // Each stage advances when it is empty or its successor advances
  assign adv3     = !v3_reg || out_ready;
  assign adv2     = !v2_reg || adv3;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1;
  assign ld1      = in_valid && adv1;
  assign ld2      = adv2 && v1_reg;
  assign ld3      = adv3 && v2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      v3_reg      <= 1'b0;
      mode_s1_reg <= ACT_HSWISH;
      mode_s2_reg <= ACT_HSWISH;
    end else begin
      if (adv1) v1_reg <= in_valid;
      if (adv2) v2_reg <= v1_reg;
      if (adv3) v3_reg <= v2_reg;
      if (ld1) mode_s1_reg <= act_mode_e'(in_mode);
      if (ld2) mode_s2_reg <= mode_s1_reg;
    end
  end

  assign out_valid = v3_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      act_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .OUT_SIZE  (OUT_SIZE),
        .RECIP6    (RECIP6)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .x      (in_data[DATA_WIDTH*gi +: DATA_WIDTH]),
        .ld1    (ld1),
        .ld2    (ld2),
        .ld3    (ld3),
        .mode_s1(mode_s1_reg),
        .mode_s2(mode_s2_reg),
        .q      (out_data[OUT_SIZE*gi +: OUT_SIZE])
`ifdef ACT_SAT_CNT_EN
        ,
        .sat    (sat_vec[gi])
`endif
      );
    end
  endgenerate

`ifdef ACT_SAT_CNT_EN
  localparam int SW = $clog2(LANES + 1);

  logic          out_fire;
  logic [SW-1:0] sat_sum;
  logic [32:0]   sat_acc;
  logic [31:0]   sat_count_next, sat_count_reg;

  assign out_fire = v3_reg && out_ready;

  // Saturating accumulate of saturated lanes per delivered beat
  always_comb begin
    sat_sum = '0;
    for (int i = 0; i < LANES; i++)
      sat_sum = sat_sum + SW'(sat_vec[i]);
    sat_acc        = {1'b0, sat_count_reg} + 33'(sat_sum);
    sat_count_next = sat_count_reg;
    if (out_fire)
      sat_count_next = sat_acc[32] ? '1 : sat_acc[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_count_reg <= '0;
    else if (sat_clr)
      sat_count_reg <= '0;
    else
      sat_count_reg <= sat_count_next;
  end

  assign sat_count = sat_count_reg;
`endif

endmodule

// File: tb/tb_act_array.sv
// Directed self-checking bench for act_array: per-mode values, saturation, backpressure,
// full-pipe stall, mid-stream reset. Counter checks are included when ACT_SAT_CNT_EN is defined.
module tb_act_array;
  import act_pkg::*;

  localparam int LANES = 16;
  localparam int DW    = 26;
  localparam int OS    = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW*LANES-1:0] in_data;
  logic [1:0]        in_mode;
  logic              in_valid;
  logic              in_ready;
  logic [OS*LANES-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef ACT_SAT_CNT_EN
  logic              sat_clr;
  logic [31:0]       sat_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  act_array dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef ACT_SAT_CNT_EN
    ,
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
`endif
  );

  typedef struct {
    logic [1:0] m;
    longint     xa;
    longint     ea;
    longint     xb;
    longint     eb;
  } vec_t;

  // Even lanes get xa, odd lanes xb; expectations computed by hand
  vec_t tbl[10] = '{
    '{ACT_HSWISH,   128,   85,  -128,   -43},
    '{ACT_HSIGMOID, 0,     64,   128,    85},
    '{ACT_RELU6,    1000,  768,  -5,     0},
    '{ACT_BYPASS,   -300,  -300, 8191,   8191},
    '{ACT_HSWISH,   512,   512,  -512,   0},
    '{ACT_HSIGMOID, -384,  0,    384,    128},
    '{ACT_RELU6,    300,   300,  768,    768},
    '{ACT_BYPASS,   8192,  8191, -8193,  -8192},
    '{ACT_HSWISH,   256,   213,  -256,   -43},
    '{ACT_HSIGMOID, -128,  42,   64,     74}
  };

  int ir_exp[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int ov_exp[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
  int ob_exp[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
  int ib_drv[10] = '{0, 1, 2, 3, 3, 3, -1, -1, -1, -1};

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint lane_out(input int i);
    logic signed [OS-1:0] v;
    v = out_data[OS*i +: OS];
    return longint'(v);
  endfunction

  task automatic set_beat(input logic [1:0] mode, input longint xa, input longint xb);
    for (int i = 0; i < LANES; i++)
      in_data[DW*i +: DW] = DW'((i % 2 == 1) ? xb : xa);
    in_mode = mode;
  endtask

  // Single beat into an empty pipe with out_ready high; checks latency and all lanes
  task automatic run_one(input string tag, input logic [1:0] mode, input longint x, input longint exp);
    int lat;
    set_beat(mode, x, x);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_ready"}, longint'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    for (int i = 0; i < LANES; i++)
      check($sformatf("%s_lane%0d", tag, i), lane_out(i), exp);
    $display("beat %s mode=%0d x=%0d lane0=%0d lat=%0d", tag, mode, x, lane_out(0), lat);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     in_idx, out_idx, cnt;
    logic   held_valid;
    logic [OS*LANES-1:0] held_data;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
`ifdef ACT_SAT_CNT_EN
    sat_clr   = 1'b0;
`endif
    #12;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(|out_data), 0);
`ifdef ACT_SAT_CNT_EN
    check("rst_sat_count", longint'(sat_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_one("hswish_1p0",  ACT_HSWISH,   128,   85);
    run_one("hswish_4p0",  ACT_HSWISH,   512,   512);
    run_one("hswish_m4",   ACT_HSWISH,   -512,  0);
    run_one("hsig_0",      ACT_HSIGMOID, 0,     64);
    run_one("relu6_hi",    ACT_RELU6,    1000,  768);
    run_one("relu6_neg",   ACT_RELU6,    -5,    0);
    run_one("bypass_neg",  ACT_BYPASS,   -300,  -300);
    run_one("hswish_sat",  ACT_HSWISH,   12800, 8191);
`ifdef ACT_SAT_CNT_EN
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("sat_clr_pre", longint'(sat_count), 0);
`endif
    run_one("bypass_min",  ACT_BYPASS,   -(64'sd1 <<< 25), -8192);
`ifdef ACT_SAT_CNT_EN
    check("sat_count16", longint'(sat_count), 16);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    check("sat_clr_post", longint'(sat_count), 0);
`endif

    // Backpressure stream: random out_ready, alternating modes
    in_idx     = 0;
    out_idx    = 0;
    held_valid = 1'b0;
    held_data  = '0;
    for (int cyc = 0; cyc < 300 && out_idx < 10; cyc++) begin
      if (held_valid) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_data", longint'(out_data == held_data), 1);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (in_idx < 10) begin
        set_beat(tbl[in_idx].m, tbl[in_idx].xa, tbl[in_idx].xb);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        for (int i = 0; i < LANES; i++)
          check($sformatf("stream%0d_lane%0d", out_idx, i), lane_out(i),
                (i % 2 == 1) ? tbl[out_idx].eb : tbl[out_idx].ea);
        $display("stream out %0d mode=%0d lane0=%0d lane1=%0d", out_idx, tbl[out_idx].m,
                 lane_out(0), lane_out(1));
        out_idx++;
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (in_valid && in_ready) in_idx++;
      @(negedge clk);
    end
    check("stream_count", out_idx, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("stream_extra", cnt, 0);

    // Full pipe held for 5 cycles, then drained one beat per cycle
    for (int c = 0; c < 10; c++) begin
      out_ready = (c >= 5);
      if (ib_drv[c] >= 0) begin
        set_beat(ACT_BYPASS, 100 + ib_drv[c], -(100 + ib_drv[c]));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check($sformatf("full_ir%0d", c), longint'(in_ready), ir_exp[c]);
      check($sformatf("full_ov%0d", c), longint'(out_valid), ov_exp[c]);
      if (ov_exp[c] == 1) begin
        check($sformatf("full_l0_%0d", c), lane_out(0), 100 + ob_exp[c]);
        check($sformatf("full_l1_%0d", c), lane_out(1), -(100 + ob_exp[c]));
      end
      $display("full cycle %0d in_ready=%0d out_valid=%0d lane0=%0d", c, in_ready, out_valid,
               lane_out(0));
      @(negedge clk);
    end

    // Reset with two beats in flight
    out_ready = 1'b1;
    set_beat(ACT_BYPASS, 7, -7);
    in_valid = 1'b1;
    @(negedge clk);
    set_beat(ACT_BYPASS, 9, -9);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_pre", longint'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_async", longint'(out_valid), 0);
    check("rst_mid_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rst_mid_dropped", cnt, 0);
    $display("reset mid-stream outputs_after=%0d", cnt);
    run_one("post_rst", ACT_HSWISH, 128, 85);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
